// File: rtl/tick_sequencer.sv
// Two-channel loop sequencer. A start pulse launches channels A and B in lock-step;
// every non-held cycle each running channel emits a registered record carrying its
// iteration index and the cycle timestamp. B reaching its last index ends the run
// and forces A off, whatever A's progress.
module tick_sequencer #(
  parameter int unsigned N_A   = 10,
  parameter int unsigned N_B   = 10,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned TS_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  output logic [TS_W-1:0]  timestamp,
  output logic             a_valid,
  output logic [CNT_W-1:0] a_index,
  output logic [TS_W-1:0]  a_time,
  output logic             b_valid,
  output logic [CNT_W-1:0] b_index,
  output logic [TS_W-1:0]  b_time,
  output logic             busy,
  output logic             done
);

  typedef enum logic {TopIdle, TopRun} top_e;
  typedef enum logic [1:0] {ChOff, ChRun, ChFin} ch_e;

  localparam logic [CNT_W-1:0] ALast = CNT_W'(N_A - 1);
  localparam logic [CNT_W-1:0] BLast = CNT_W'(N_B - 1);

  top_e             top_q, top_d;
  ch_e              a_st_q, a_st_d, b_st_q, b_st_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic             a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [CNT_W-1:0] a_index_q, a_index_d, b_index_q, b_index_d;
  logic [TS_W-1:0]  a_time_q, a_time_d, b_time_q, b_time_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             fin_q, fin_d;
  logic             accept, active;

  // Next-state: start acceptance, per-channel emission and run termination.
  always_comb begin
    top_d     = top_q;
    a_st_d    = a_st_q;
    b_st_d    = b_st_q;
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    ts_d      = ts_q + TS_W'(1);
    a_valid_d = 1'b0;
    b_valid_d = 1'b0;
    a_index_d = a_index_q;
    b_index_d = b_index_q;
    a_time_d  = a_time_q;
    b_time_d  = b_time_q;
    fin_d     = 1'b0;
    // done trails the last B record by one cycle
    done_d    = fin_q;

    // busy_q also covers the cycle showing B's last record, when top is already idle
    accept = (top_q == TopIdle) && !busy_q && start;
    active = accept || (top_q == TopRun);
    busy_d = active;

    if (accept) begin
      top_d   = TopRun;
      a_st_d  = ChRun;
      b_st_d  = ChRun;
      a_cnt_d = '0;
      b_cnt_d = '0;
    end

    if (active && !hold) begin
      if (a_st_d == ChRun) begin
        a_valid_d = 1'b1;
        a_index_d = a_cnt_d;
        a_time_d  = ts_d;
        if (a_cnt_d == ALast) a_st_d = ChFin;
        else                  a_cnt_d = a_cnt_d + CNT_W'(1);
      end
      if (b_st_d == ChRun) begin
        b_valid_d = 1'b1;
        b_index_d = b_cnt_d;
        b_time_d  = ts_d;
        if (b_cnt_d == BLast) begin
          top_d  = TopIdle;
          a_st_d = ChOff;
          b_st_d = ChOff;
          fin_d  = 1'b1;
        end else begin
          b_cnt_d = b_cnt_d + CNT_W'(1);
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_q     <= TopIdle;
      a_st_q    <= ChOff;
      b_st_q    <= ChOff;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      ts_q      <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_index_q <= '0;
      b_index_q <= '0;
      a_time_q  <= '0;
      b_time_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      top_q     <= top_d;
      a_st_q    <= a_st_d;
      b_st_q    <= b_st_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
      ts_q      <= ts_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      a_index_q <= a_index_d;
      b_index_q <= b_index_d;
      a_time_q  <= a_time_d;
      b_time_q  <= b_time_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fin_q     <= fin_d;
    end
  end

  assign timestamp = ts_q;
  assign a_valid   = a_valid_q;
  assign a_index   = a_index_q;
  assign a_time    = a_time_q;
  assign b_valid   = b_valid_q;
  assign b_index   = b_index_q;
  assign b_time    = b_time_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: a default instance (10/10, 32-bit time) and a cut-short,
// narrow-timestamp instance (15/4, 4-bit time) share stimulus. A record-count model
// is checked every cycle, plus directed literal expectations.
module tb_tick_sequencer;

  logic clk, rst, start, hold;

  logic [31:0] d0_ts, d0_at, d0_bt;
  logic [7:0]  d0_ai, d0_bi;
  logic        d0_av, d0_bv, d0_busy, d0_done;
  logic [3:0]  d1_ts, d1_at, d1_bt;
  logic [7:0]  d1_ai, d1_bi;
  logic        d1_av, d1_bv, d1_busy, d1_done;

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_en = 0;

  tick_sequencer #(.N_A(10), .N_B(10), .CNT_W(8), .TS_W(32)) dut0 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .timestamp(d0_ts),
    .a_valid(d0_av), .a_index(d0_ai), .a_time(d0_at),
    .b_valid(d0_bv), .b_index(d0_bi), .b_time(d0_bt),
    .busy(d0_busy), .done(d0_done)
  );

  tick_sequencer #(.N_A(15), .N_B(4), .CNT_W(8), .TS_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .timestamp(d1_ts),
    .a_valid(d1_av), .a_index(d1_ai), .a_time(d1_at),
    .b_valid(d1_bv), .b_index(d1_bi), .b_time(d1_bt),
    .busy(d1_busy), .done(d1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: k counts records emitted in the current run.
  typedef struct {
    bit     busy, run, pend, done, av, bv;
    longint k, ts, a_idx, a_time, b_idx, b_time;
  } mstate_t;

  mstate_t m0, m1;

  function automatic mstate_t step(mstate_t s, longint na, longint nb, int tsw,
                                   bit r, bit st, bit hd);
    mstate_t n;
    n = s;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n.ts   = (s.ts + 1) % (longint'(1) << tsw);
    n.done = s.pend;
    n.pend = 0;
    n.av   = 0;
    n.bv   = 0;
    if (st && !s.busy) begin
      n.run = 1;
      n.k   = 0;
    end
    n.busy = n.run;
    if (n.run && !hd) begin
      n.bv = 1; n.b_idx = n.k; n.b_time = n.ts;
      if (n.k < na) begin
        n.av = 1; n.a_idx = n.k; n.a_time = n.ts;
      end
      if (n.k == nb - 1) begin
        n.run  = 0;
        n.pend = 1;
      end
      n.k = n.k + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m0 <= step(m0, 10, 10, 32, rst, start, hold);
    m1 <= step(m1, 15, 4, 4, rst, start, hold);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_all(input string p, input mstate_t m, input logic [63:0] ts,
                         input logic av, input logic [63:0] ai, input logic [63:0] at,
                         input logic bv, input logic [63:0] bi, input logic [63:0] bt,
                         input logic bsy, input logic dn);
    check({p, "_timestamp"}, ts, m.ts);
    check({p, "_a_valid"}, 64'(av), 64'(m.av));
    check({p, "_b_valid"}, 64'(bv), 64'(m.bv));
    check({p, "_busy"}, 64'(bsy), 64'(m.busy));
    check({p, "_done"}, 64'(dn), 64'(m.done));
    if (m.av) begin
      check({p, "_a_index"}, ai, m.a_idx);
      check({p, "_a_time"}, at, m.a_time);
    end
    if (m.bv) begin
      check({p, "_b_index"}, bi, m.b_idx);
      check({p, "_b_time"}, bt, m.b_time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_all("d0", m0, 64'(d0_ts), d0_av, 64'(d0_ai), 64'(d0_at), d0_bv, 64'(d0_bi),
              64'(d0_bt), d0_busy, d0_done);
      cmp_all("d1", m1, 64'(d1_ts), d1_av, 64'(d1_ai), 64'(d1_at), d1_bv, 64'(d1_bi),
              64'(d1_bt), d1_busy, d1_done);
    end
  end

  task automatic wait_ts0(input longint v);
    bit found;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (d0_ts == v) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("wait_timestamp", 64'(found), 64'd1);
  endtask

  task automatic wait_done0();
    bit found;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (d0_done === 1'b1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("wait_done", 64'(found), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] t3;
    rst   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    @(posedge clk);
    #1 chk_en = 1;
    // Three reset edges in total, then release; timestamp reads 0,1,2.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ts0", 64'(d0_ts), 64'd0);
    check("rst_busy", 64'(d0_busy), 64'd0);
    check("rst_a_valid", 64'(d0_av), 64'd0);
    @(negedge clk);
    check("rst_ts1", 64'(d0_ts), 64'd1);
    @(negedge clk);
    check("rst_ts2", 64'(d0_ts), 64'd2);

    // Default run: start sampled at the edge leaving timestamp 5.
    wait_ts0(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("run_a_valid", 64'(d0_av), 64'd1);
      check("run_b_valid", 64'(d0_bv), 64'd1);
      check("run_a_index", 64'(d0_ai), 64'(i));
      check("run_a_time", 64'(d0_at), 64'(6 + i));
      check("run_b_time", 64'(d0_bt), 64'(6 + i));
      check("run_busy", 64'(d0_busy), 64'd1);
      if (i < 4) begin
        check("cut_a_valid", 64'(d1_av), 64'd1);
        check("cut_a_index", 64'(d1_ai), 64'(i));
        check("cut_b_index", 64'(d1_bi), 64'(i));
      end else begin
        check("cut_a_off", 64'(d1_av), 64'd0);
      end
      if (i == 4) check("cut_done", 64'(d1_done), 64'd1);
      @(negedge clk);
    end
    check("run_done", 64'(d0_done), 64'd1);
    check("run_done_busy", 64'(d0_busy), 64'd0);
    check("run_done_ts", 64'(d0_ts), 64'd16);

    // Start in the done cycle is accepted.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_idx0", 64'(d0_ai), 64'd0);
    check("restart_valid", 64'(d0_av), 64'd1);
    @(negedge clk);
    @(negedge clk);
    // Start mid-run is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignore_idx3", 64'(d0_ai), 64'd3);
    t3 = d0_at;
    check("hold_t3", 64'(t3), 64'd20);
    hold = 1'b1;
    @(negedge clk);
    check("hold1_a_valid", 64'(d0_av), 64'd0);
    check("hold1_b_valid", 64'(d0_bv), 64'd0);
    check("hold1_busy", 64'(d0_busy), 64'd1);
    @(negedge clk);
    check("hold2_a_valid", 64'(d0_av), 64'd0);
    hold = 1'b0;
    @(negedge clk);
    check("hold_idx4", 64'(d0_ai), 64'd4);
    check("hold_t4", 64'(d0_at), 64'(t3 + 3));
    wait_done0();
    check("hold_done_ts", 64'(d0_ts), 64'd29);

    // Restart in done cycle; narrow instance wraps 15 -> 0.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("wrap_d0_idx0", 64'(d0_ai), 64'd0);
    check("wrap_bt14", 64'(d1_bt), 64'd14);
    @(negedge clk);
    check("wrap_bt15", 64'(d1_bt), 64'd15);
    @(negedge clk);
    check("wrap_bt0", 64'(d1_bt), 64'd0);
    @(negedge clk);
    check("wrap_bt1", 64'(d1_bt), 64'd1);
    @(negedge clk);
    check("wrap_done", 64'(d1_done), 64'd1);
    @(negedge clk);
    // Abort at index 5.
    check("abort_idx5", 64'(d0_ai), 64'd5);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ts", 64'(d0_ts), 64'd0);
    check("abort_busy", 64'(d0_busy), 64'd0);
    check("abort_a_valid", 64'(d0_av), 64'd0);
    check("abort_a_index", 64'(d0_ai), 64'd0);
    check("abort_b_time", 64'(d0_bt), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(d0_done), 64'd0);
    end
    check("abort_ts_after", 64'(d0_ts), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tick_sequencer.md
# tick_sequencer

Synthesizable two-channel loop sequencer: on a start pulse it runs two independent iteration counters in lock-step with a free-running cycle timestamp. Each iteration emits a one-cycle record carrying the iteration index and timestamp. Completion of channel B terminates the whole run and also cuts channel A short. It is the hardware counterpart of our cycle-stepped simulation flows: the design generates and time-stamps the iteration events itself, so benches only observe and check them.

## Interface
- `N_A`, default 10: iterations for channel A; must be ≥ 1.
- `N_B`, default 10: iterations for channel B, which is the terminating channel; must be ≥ 1.
- `CNT_W`, default 8: index width; must satisfy 2^CNT_W ≥ max(N_A, N_B).
- `TS_W`, default 32: timestamp width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request, sampled on the rising edge.
- `hold` in 1: pause both channels while high.
- `timestamp` out TS_W: free-running cycle count.
- `a_valid` out 1: channel A iteration record valid.
- `a_index` out CNT_W: channel A iteration number.
- `a_time` out TS_W: timestamp of that A iteration.
- `b_valid`, `b_index`, `b_time`: same as the A outputs, for channel B.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse when a run ends.

## Operation
- Top FSM has two states:
  - IDLE -> RUN on `start` = 1.
  - RUN -> IDLE when channel B issues index N_B-1.
- Per-channel state is RUN, FIN or OFF:
  - Both channels enter RUN with index 0 on an accepted start.
  - Each non-held RUN cycle emits `x_valid` = 1, `x_index` = current index and `x_time` = `timestamp` of that same cycle, then increments the index.
  - After emitting index N-1 the channel moves to FIN and emits no more records.
- Termination when B emits N_B-1:
  - Channel A goes OFF on the same edge, whatever its progress.
  - The top FSM returns to IDLE.
  - `done` pulses on the next cycle.
- `hold` = 1 in RUN:
  - `a_valid` = `b_valid` = 0.
  - Indexes are frozen.
  - `timestamp` keeps counting.
  - `busy` stays 1.
- `start` while `busy` = 1 is ignored. `start` in the `done` cycle is accepted, because `busy` is already 0.
- `timestamp` increments every cycle, including in IDLE and under hold. It wraps from 2^TS_W-1 to 0. `x_time` reports the wrapped value; no saturation.
- Index counters never wrap, because termination occurs at N-1.
- If N_A ≤ N_B:
  - A emits all N_A records.
  - A then sits in FIN until B finishes.
- If N_A > N_B: A emits exactly N_B records, indexes 0..N_B-1, and is then forced OFF.
- `x_index` and `x_time` are don't-care when `x_valid` = 0. They must be held stable (the last value), not X.

## Timing
- Reset values: every output is 0, both FSMs are in IDLE/OFF, and the `timestamp` register is 0.
- `rst` asserted mid-run:
  - The run is aborted on that edge, with no `done` pulse.
  - The first cycle after reset release shows `timestamp` = 0.
- Start latency: `start` sampled at edge k gives `busy` = 1 and the first records (index 0 on both channels) in the cycle following edge k.
- Without hold:
  - Records on consecutive cycles.
  - B's last record is N_B-1 cycles after its first.
- Last-record cycle: `busy` = 1.
- Next cycle: `busy` = 0 and `done` = 1 for exactly one cycle.
- Each hold cycle delays every later record, and `done`, by one cycle.
- `hold` asserted in the same cycle `start` is sampled: the start is still accepted; records begin in the first non-held cycle.
- All outputs are registered; no combinational path from input to output.

## Test plan
- **Reset:** hold `rst` 3 cycles, release → all outputs 0 and `timestamp` reads 0,1,2… on successive cycles.
- **Default run:** N_A = N_B = 10, `start` pulse at edge where `timestamp` = 5:
  - `a_valid` and `b_valid` high for 10 consecutive cycles.
  - Indexes 0..9, `x_time` 6..15.
  - `done` at `timestamp` 16, with `busy` low in that cycle.
- **Cut-short:** N_A = 15, N_B = 4 → A emits indexes 0..3 only, then OFF; `done` one cycle after B index 3; no further A records.
- **Hold:**
  - Stimulus: N_A = N_B = 10; assert `hold` for 2 cycles after index 3.
  - Both `x_valid` are 0 for those 2 cycles.
  - Index 4 has `x_time` exactly 3 greater than index 3.
  - `done` is 2 cycles later than the unheld run.
- **Restart and ignore:**
  - `start` during a run → ignored; no index reset.
  - `start` in the `done` cycle → new run, index 0 on the next cycle.
- **Wrap and abort:**
  - TS_W = 4, run across `timestamp` 15 → `x_time` sequence shows 15 then 0.
  - Separately, `rst` at index 5 → outputs 0, no `done` pulse.
